cpu_trace_buffer: RTL and testbench

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

---
 rtl/cpu_trace_buffer.sv | 115 +++++++++++
 tb/tb_cpu_trace_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Trace buffer for a small CPU: circular capture of {PC, op, rs, rt, rd, result}
// around a programmable trigger, frozen afterwards for oldest-first readout.
module cpu_trace_buffer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [3:0]                    op,
  input  logic [3:0]                    rs,
  input  logic [3:0]                    rt,
  input  logic [3:0]                    rd,
  input  logic [ADDR_W-1:0]             currentAddress,
  input  logic [DATA_W-1:0]             result,
  input  logic                          arm,
  input  logic [1:0]                    trig_mode,
  input  logic [ADDR_W-1:0]             trig_pc,
  input  logic [3:0]                    trig_op,
  input  logic                          trig_manual,
  input  logic                          rd_en,
  output logic [ADDR_W+16+DATA_W-1:0]   rd_data,
  output logic                          rd_valid,
  output logic [1:0]                    state,
  output logic                          triggered,
  output logic [$clog2(DEPTH):0]        count
);
  localparam int AW = $clog2(DEPTH);
  localparam int E  = ADDR_W + 16 + DATA_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t          st;
  logic [E-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   post_left;
  logic [AW-1:0]   rd_idx;
  logic [E-1:0]    sample;
  logic            hit;
  logic            wr_en;

  assign state  = st;
  assign sample = {currentAddress, op, rs, rt, rd, result};
  assign wr_en  = !arm && (st == ARMED || st == POST);
  // Oldest entry sits count slots behind the write pointer; a full buffer wraps to wr_ptr itself.
  assign rd_idx = wr_ptr - count[AW-1:0];

  always_comb begin
    hit = 1'b0;
    case (trig_mode)
      2'd0:    hit = 1'b1;
      2'd1:    hit = (currentAddress == trig_pc);
      2'd2:    hit = (op == trig_op);
      default: hit = trig_manual;
    endcase
  end

  // Storage carries no reset; count==0 after reset keeps stale entries unreadable.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      triggered <= 1'b0;
      post_left <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (arm) begin
        st        <= ARMED;
        wr_ptr    <= '0;
        count     <= '0;
        triggered <= 1'b0;
        post_left <= '0;
      end else begin
        case (st)
          ARMED: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != FULL) count <= count + 1'b1;
            if (hit) begin
              triggered <= 1'b1;
              if (POST_TRIG > 0) begin
                st        <= POST;
                post_left <= AW'(POST_TRIG);
              end else begin
                st <= DONE;
              end
            end
          end
          POST: begin
            wr_ptr    <= wr_ptr + 1'b1;
            if (count != FULL) count <= count + 1'b1;
            post_left <= post_left - 1'b1;
            if (post_left == 1) st <= DONE;
          end
          DONE: begin
            if (rd_en && count != '0) begin
              rd_data  <= mem[rd_idx];
              rd_valid <= 1'b1;
              count    <= count - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: a queue model of the trace window is filled
// while samples are driven and drained against each popped entry.
module tb_cpu_trace_buffer;
  localparam int DEPTH = 64;
  localparam int POST_TRIG = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  op, rs, rt, rd, trig_op;
  logic [15:0] currentAddress, result, trig_pc;
  logic        arm, trig_manual, rd_en;
  logic [1:0]  trig_mode;
  logic [47:0] rd_data;
  logic        rd_valid, triggered;
  logic [1:0]  state;
  logic [6:0]  count;

  int compared = 0;
  int mismatched = 0;
  logic [47:0] exp_q[$];
  logic [47:0] trig_e;
  logic [47:0] last_e;

  cpu_trace_buffer #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .CLK(CLK), .RESET(RESET), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .currentAddress(currentAddress), .result(result), .arm(arm),
    .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_op(trig_op),
    .trig_manual(trig_manual), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .state(state), .triggered(triggered), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Arms, then feeds PC = 0,1,2... while the model tracks which samples land in the window.
  task automatic run_capture(input logic [1:0] mode, input logic [15:0] tpc,
                             input int op_at, input int man_at, input bit rd_during);
    int phase;
    int post_left;
    int n;
    bit fire;
    logic [47:0] e;
    arm = 1'b1; trig_mode = mode; trig_pc = tpc; trig_op = 4'hF;
    step();
    arm = 1'b0;
    chk("armed_state", 64'(state), 64'd1);
    chk("armed_count", 64'(count), 64'd0);
    chk("armed_trig", 64'(triggered), 64'd0);
    exp_q.delete();
    phase = 1; post_left = 0; n = 0;
    while (phase != 3 && n < 400) begin
      currentAddress = n[15:0];
      op = (n == op_at) ? 4'hF : 4'(n % 15);
      rs = 4'($urandom); rt = 4'($urandom); rd = 4'($urandom);
      result = 16'($urandom);
      trig_manual = (n == man_at);
      rd_en = rd_during;
      e = {currentAddress, op, rs, rt, rd, result};
      exp_q.push_back(e);
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      if (phase == 1) begin
        case (mode)
          2'd0: fire = 1'b1;
          2'd1: fire = (currentAddress == tpc);
          2'd2: fire = (op == 4'hF);
          default: fire = trig_manual;
        endcase
        if (fire) begin
          trig_e = e;
          post_left = POST_TRIG;
          phase = (POST_TRIG > 0) ? 2 : 3;
        end
      end else begin
        post_left--;
        if (post_left == 0) phase = 3;
      end
      step();
      n++;
      if (rd_during) chk("rd_in_capture", 64'(rd_valid), 64'd0);
    end
    rd_en = 1'b0; trig_manual = 1'b0;
    chk("done_state", 64'(state), 64'd3);
    chk("done_trig", 64'(triggered), 64'd1);
    chk("done_count", 64'(count), 64'(exp_q.size()));
  endtask

  // Back-to-back pops; each rd_valid pulse is matched to the oldest queued sample.
  task automatic read_all(input logic [15:0] first_pc);
    int n;
    logic [47:0] e;
    n = exp_q.size();
    rd_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      rd_en = (k + 1 < n);
      chk("rd_valid", 64'(rd_valid), 64'd1);
      e = exp_q.pop_front();
      chk("rd_data", 64'(rd_data), 64'(e));
      if (k == 0) chk("first_pc", 64'(rd_data[47:32]), 64'(first_pc));
      if (k == n - POST_TRIG - 1) chk("trig_entry", 64'(rd_data), 64'(trig_e));
      chk("rd_count", 64'(count), 64'(n - k - 1));
      last_e = e;
    end
    step();
    chk("rd_valid_low", 64'(rd_valid), 64'd0);
    chk("rd_data_hold", 64'(rd_data), 64'(last_e));
  endtask

  initial begin
    RESET = 1'b1; arm = 1'b0; trig_mode = 2'd0; trig_pc = '0; trig_op = '0;
    trig_manual = 1'b0; rd_en = 1'b0; op = '0; rs = '0; rt = '0; rd = '0;
    currentAddress = '0; result = '0;
    #2 RESET = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_trig", 64'(triggered), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    repeat (2) step();
    RESET = 1'b1;

    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("idle_rd_valid", 64'(rd_valid), 64'd0);
    chk("idle_state", 64'(state), 64'd0);

    // Immediate trigger: 9 entries, PC 0..8.
    run_capture(2'd0, 16'h0, -1, -1, 1'b0);
    read_all(16'h0000);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty_rd_valid", 64'(rd_valid), 64'd0);
    chk("empty_count", 64'(count), 64'd0);

    // PC match at 0x30 with rd_en held while armed: 57 entries from PC 0.
    run_capture(2'd1, 16'h0030, -1, -1, 1'b1);
    chk("pcm_count", 64'(count), 64'd57);
    read_all(16'h0000);

    // Opcode match after 200 cycles: buffer wraps, oldest is 55 before trigger.
    run_capture(2'd2, 16'h0, 200, -1, 1'b0);
    chk("wrap_count", 64'(count), 64'd64);
    read_all(16'd145);

    // Arm beats a manual trigger arriving during POST.
    arm = 1'b1; trig_mode = 2'd3;
    step();
    arm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      currentAddress = 16'(i);
      trig_manual = (i == 2);
      step();
    end
    chk("man_post_state", 64'(state), 64'd2);
    chk("man_post_trig", 64'(triggered), 64'd1);
    chk("man_post_count", 64'(count), 64'd6);
    arm = 1'b1; trig_manual = 1'b1;
    step();
    arm = 1'b0; trig_manual = 1'b0;
    chk("rearm_state", 64'(state), 64'd1);
    chk("rearm_count", 64'(count), 64'd0);
    chk("rearm_trig", 64'(triggered), 64'd0);
    step();
    chk("rearm_count1", 64'(count), 64'd1);

    // Asynchronous reset mid-POST, then a clean capture.
    arm = 1'b1; trig_mode = 2'd0;
    step();
    arm = 1'b0;
    repeat (3) step();
    chk("pre_rst_state", 64'(state), 64'd2);
    #2 RESET = 1'b0;
    #1;
    chk("async_state", 64'(state), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(rd_valid), 64'd0);
    chk("async_trig", 64'(triggered), 64'd0);
    step();
    RESET = 1'b1;
    step();
    chk("post_rst_idle", 64'(state), 64'd0);
    run_capture(2'd0, 16'h0, -1, -1, 1'b0);
    read_all(16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
